// File: rtl/pq_pkg.sv
// pq_pkg: shared key/value type, command opcode enum and sizing constants for pq_front.
package pq_pkg;
    localparam int KEY_WIDTH   = 8;
    localparam int VAL_WIDTH   = 8;
    localparam int PQ_CAPACITY = 8;

    typedef struct packed {
        logic [KEY_WIDTH-1:0] key;
        logic [VAL_WIDTH-1:0] val;
    } kv_t;

    typedef enum logic [1:0] {
        OP_ENQ     = 2'b00,
        OP_DEQ     = 2'b01,
        OP_REPLACE = 2'b10,
        OP_NOP     = 2'b11
    } pq_op_t;

    typedef struct packed {
        pq_op_t op;
        kv_t    kv;
    } cmd_t;

    localparam int CMD_WIDTH = $bits(cmd_t);
endpackage

// File: rtl/pq_front_cmd_fifo.sv
// cmd_fifo: synchronous FIFO with registered head data and full/empty flags.
//   clk, rst      clock, synchronous active-high reset
//   push, din     write request and data (ignored while full)
//   pop           read request (ignored while empty, so a push into an empty FIFO is never popped the same cycle)
//   dout          registered head entry
//   full, empty   registered status flags
module cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             full_q, full_d, empty_q, empty_d;
    logic             do_push, do_pop;

    always_comb begin
        do_push = push && !full_q;
        do_pop  = pop && !empty_q;
        wr_d    = wr_q + AW'(do_push);
        rd_d    = rd_q + AW'(do_pop);
        cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        full_d  = cnt_d == (AW+1)'(DEPTH);
        empty_d = cnt_d == '0;
        // The next head is either already stored or is the word being written right now.
        dout_d  = (do_push && wr_q == rd_d) ? din : mem_q[rd_d];
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
        if (rst) begin
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    assign dout  = dout_q;
    assign full  = full_q;
    assign empty = empty_q;
endmodule

// File: rtl/pq_front.sv
// pq_front: command FIFO plus issue FSM in front of a priority queue.
//   cmd_valid/cmd_op/cmd_kv/cmd_ready   command input stream
//   res_valid/res_kv/res_err/res_ready  dequeue result output
//   pq_enq/pq_deq/pq_kvi                strobes and data to the downstream PQ
//   pq_kvo/pq_full/pq_empty/pq_busy     PQ head and status
//   op_count                            number of PQ operations issued (wraps)
module pq_front
    import pq_pkg::*;
#(
    parameter int CMD_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd_op,
    input  kv_t         cmd_kv,
    output logic        cmd_ready,
    output logic        res_valid,
    output kv_t         res_kv,
    output logic        res_err,
    input  logic        res_ready,
    output logic        pq_enq,
    output logic        pq_deq,
    output kv_t         pq_kvi,
    input  kv_t         pq_kvo,
    input  logic        pq_full,
    input  logic        pq_empty,
    input  logic        pq_busy,
    output logic [15:0] op_count
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t      state_q, state_d;
    logic        pq_enq_q, pq_enq_d, pq_deq_q, pq_deq_d;
    kv_t         pq_kvi_q, pq_kvi_d;
    logic        res_valid_q, res_valid_d, res_err_q, res_err_d;
    kv_t         res_kv_q, res_kv_d;
    logic [15:0] op_count_q, op_count_d;
    logic        fifo_full, fifo_empty, pop, eligible;
    cmd_t        cmd_in, head;

    assign cmd_in = '{op: pq_op_t'(cmd_op), kv: cmd_kv};

    cmd_fifo #(
        .WIDTH(CMD_WIDTH),
        .DEPTH(CMD_DEPTH)
    ) u_cmd_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (cmd_valid),
        .din  (cmd_in),
        .pop  (pop),
        .dout (head),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        pq_enq_d    = 1'b0;
        pq_deq_d    = 1'b0;
        pq_kvi_d    = '0;
        res_valid_d = res_valid_q && !res_ready;
        res_kv_d    = res_kv_q;
        res_err_d   = res_err_q;
        op_count_d  = op_count_q;
        pop         = 1'b0;
        eligible    = head.op == OP_ENQ ? !pq_full : head.op == OP_NOP ? 1'b1 : !res_valid_q;
        case (state_q)
            S_IDLE: begin
                // Strobes are decided here so they are registered and live exactly during ISSUE.
                if (!fifo_empty && !pq_busy && eligible) begin
                    state_d  = S_ISSUE;
                    pq_enq_d = head.op == OP_ENQ || head.op == OP_REPLACE;
                    pq_deq_d = (head.op == OP_DEQ || head.op == OP_REPLACE) && !pq_empty;
                    pq_kvi_d = head.kv;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                pop     = 1'b1;
                if (pq_enq_q || pq_deq_q) op_count_d = op_count_q + 16'd1;
                if (pq_deq_q) begin
                    res_valid_d = 1'b1;
                    res_err_d   = 1'b0;
                    res_kv_d    = pq_kvo;
                end else if (head.op == OP_DEQ) begin
                    res_valid_d = 1'b1;
                    res_err_d   = 1'b1;
                    res_kv_d    = '0;
                end
            end
            S_WAIT:  state_d = pq_busy ? S_WAIT : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pq_enq_q    <= 1'b0;
            pq_deq_q    <= 1'b0;
            pq_kvi_q    <= '0;
            res_valid_q <= 1'b0;
            res_kv_q    <= '0;
            res_err_q   <= 1'b0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            pq_enq_q    <= pq_enq_d;
            pq_deq_q    <= pq_deq_d;
            pq_kvi_q    <= pq_kvi_d;
            res_valid_q <= res_valid_d;
            res_kv_q    <= res_kv_d;
            res_err_q   <= res_err_d;
            op_count_q  <= op_count_d;
        end
    end

    assign cmd_ready = !fifo_full;
    assign res_valid = res_valid_q;
    assign res_kv    = res_kv_q;
    assign res_err   = res_err_q;
    assign pq_enq    = pq_enq_q;
    assign pq_deq    = pq_deq_q;
    assign pq_kvi    = pq_kvi_q;
    assign op_count  = op_count_q;
endmodule

// File: tb/tb_pq_front.sv
// tb_pq_front: directed bench for pq_front with a behavioural sorted-PQ stand-in.
module tb_pq_front;
    import pq_pkg::*;

    logic        clk = 1'b0;
    logic        rst, cmd_valid, cmd_ready, res_valid, res_err, res_ready;
    logic [1:0]  cmd_op;
    kv_t         cmd_kv, res_kv, pq_kvi, pq_kvo;
    logic        pq_enq, pq_deq, pq_full, pq_empty, pq_busy;
    logic [15:0] op_count;
    logic        force_full = 1'b0, force_busy = 1'b0;

    int checks = 0, errors = 0;
    int cyc = 0, enq_n = 0, deq_n = 0, both_n = 0, last_deq = 0;
    kv_t last_kvi = '0;

    always #5 clk = ~clk;

    pq_front #(.CMD_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_kv(cmd_kv),
        .cmd_ready(cmd_ready), .res_valid(res_valid), .res_kv(res_kv), .res_err(res_err),
        .res_ready(res_ready), .pq_enq(pq_enq), .pq_deq(pq_deq), .pq_kvi(pq_kvi),
        .pq_kvo(pq_kvo), .pq_full(pq_full), .pq_empty(pq_empty), .pq_busy(pq_busy),
        .op_count(op_count)
    );

    kv_t  m_q [PQ_CAPACITY];
    kv_t  m_d [PQ_CAPACITY];
    int   cnt_q = 0, cnt_d, p;
    logic busy_q = 1'b0;

    always_comb begin
        m_d   = m_q;
        cnt_d = cnt_q;
        p     = 0;
        if (pq_deq && cnt_d > 0) begin
            for (int i = 0; i < PQ_CAPACITY - 1; i++) m_d[i] = m_d[i+1];
            cnt_d = cnt_d - 1;
        end
        if (pq_enq && cnt_d < PQ_CAPACITY) begin
            p = cnt_d;
            for (int i = PQ_CAPACITY - 1; i >= 0; i--)
                if (i < cnt_d && m_d[i].key > pq_kvi.key) p = i;
            for (int i = PQ_CAPACITY - 1; i > 0; i--)
                if (i > p) m_d[i] = m_d[i-1];
            m_d[p] = pq_kvi;
            cnt_d  = cnt_d + 1;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            cnt_q  <= 0;
            busy_q <= 1'b0;
        end else begin
            m_q    <= m_d;
            cnt_q  <= cnt_d;
            busy_q <= pq_enq || pq_deq;
        end
        cyc <= cyc + 1;
        if (pq_enq) begin
            enq_n    <= enq_n + 1;
            last_kvi <= pq_kvi;
        end
        if (pq_deq) begin
            deq_n    <= deq_n + 1;
            last_deq <= cyc;
        end
        if (pq_enq && pq_deq) both_n <= both_n + 1;
    end

    assign pq_kvo   = cnt_q > 0 ? m_q[0] : '0;
    assign pq_empty = cnt_q == 0;
    assign pq_full  = force_full || cnt_q == PQ_CAPACITY;
    assign pq_busy  = busy_q || force_busy;

    function automatic kv_t mk(input logic [7:0] k);
        mk.key = k;
        mk.val = k + 8'd100;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] op, input logic [7:0] key);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_kv    = mk(key);
        while (!cmd_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!cmd_ready) check("push_timeout", 0, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_res();
        int n = 0;
        while (!res_valid && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("res_wait", res_valid, 1);
    endtask

    task automatic get_res(output kv_t kv, output logic err);
        wait_res();
        kv  = res_kv;
        err = res_err;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
    endtask

    kv_t  kv;
    logic err;
    int   e0, d0, b0, raise_cyc;
    logic [15:0] o0;

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_kv = '0; res_ready = 1'b0;
        settle(3);
        rst = 1'b0;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_kv", res_kv, 0);
        check("rst_res_err", res_err, 0);
        check("rst_pq_enq", pq_enq, 0);
        check("rst_pq_deq", pq_deq, 0);
        check("rst_pq_kvi", pq_kvi, 0);
        check("rst_op_count", op_count, 0);

        push(OP_ENQ, 5); push(OP_ENQ, 2); push(OP_ENQ, 9); push(OP_DEQ, 0);
        get_res(kv, err);
        check("deq1_kv", kv, mk(2)); check("deq1_err", err, 0);
        check("res_cleared", res_valid, 0);
        push(OP_DEQ, 0);
        get_res(kv, err);
        check("deq2_kv", kv, mk(5)); check("deq2_err", err, 0);
        push(OP_DEQ, 0);
        get_res(kv, err);
        check("deq3_kv", kv, mk(9)); check("deq3_err", err, 0);
        settle(5);
        check("sort_op_count", op_count, 6);

        d0 = deq_n;
        push(OP_DEQ, 0);
        get_res(kv, err);
        check("empty_kv", kv, 0); check("empty_err", err, 1);
        check("empty_no_deq", deq_n, d0); check("empty_op_count", op_count, 6);

        force_full = 1'b1;
        e0 = enq_n; d0 = deq_n;
        push(OP_ENQ, 4); push(OP_DEQ, 0); push(OP_NOP, 0); push(OP_NOP, 0);
        settle(6);
        check("full_cmd_ready", cmd_ready, 0);
        check("full_no_enq", enq_n, e0); check("full_no_deq", deq_n, d0);
        check("full_op_count", op_count, 6);
        force_full = 1'b0;
        get_res(kv, err);
        check("full_order_kv", kv, mk(4)); check("full_order_err", err, 0);
        check("full_enq_once", enq_n, e0 + 1);
        settle(10);
        check("full_op_count2", op_count, 8);
        check("full_cmd_ready2", cmd_ready, 1);

        d0 = deq_n;
        push(OP_ENQ, 8); push(OP_ENQ, 1); push(OP_DEQ, 0); push(OP_DEQ, 0);
        settle(20);
        check("stall_res_valid", res_valid, 1);
        check("stall_res_kv", res_kv, mk(1));
        check("stall_one_deq", deq_n, d0 + 1);
        raise_cyc = cyc;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        for (int n = 0; n < 50 && deq_n != d0 + 2; n++) settle(1);
        check("stall_second_deq", deq_n, d0 + 2);
        check("stall_gap_ge2", (last_deq - raise_cyc) >= 2, 1);
        get_res(kv, err);
        check("stall_kv2", kv, mk(8));

        push(OP_ENQ, 3);
        settle(6);
        o0 = op_count; b0 = both_n;
        push(OP_REPLACE, 7);
        get_res(kv, err);
        check("repl_kv", kv, mk(3)); check("repl_err", err, 0);
        check("repl_both_once", both_n, b0 + 1);
        check("repl_op_count", op_count, o0 + 16'd1);
        check("repl_kvi", last_kvi, mk(7));
        check("idle_kvi_zero", pq_kvi, 0);

        push(OP_DEQ, 0);
        wait_res();
        check("pend_kv", res_kv, mk(7));
        force_full = 1'b1;
        push(OP_ENQ, 1); push(OP_DEQ, 0); push(OP_DEQ, 0); push(OP_DEQ, 0);
        force_full = 1'b0;
        for (int n = 0; n < 50 && !pq_enq; n++) settle(1);
        check("wait_enq_issue", pq_enq, 1);
        force_busy = 1'b1;
        settle(1);
        check("wait_three_queued", cmd_ready, 1);
        rst = 1'b1;
        settle(1);
        rst = 1'b0;
        force_busy = 1'b0;
        d0 = deq_n;
        check("wrst_cmd_ready", cmd_ready, 1);
        check("wrst_res_valid", res_valid, 0);
        check("wrst_op_count", op_count, 0);
        settle(10);
        check("wrst_fifo_empty", res_valid, 0);
        check("wrst_no_deq", deq_n, d0);
        check("wrst_op_count2", op_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule

// File: doc/pq_front.md
PQ_FRONT -- requirements
Module: pq_front

Interface
REQ-001 Parameter CMD_DEPTH, default 4, sets the command FIFO depth (power of two, at least 2).
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 cmd_valid  input  1  producer presents a command.
REQ-005 cmd_op  input  2  00=ENQ, 01=DEQ, 10=REPLACE, 11=reserved (treated as NOP, consumed, no PQ access).
REQ-006 cmd_kv  input  kv_t  key/value for ENQ/REPLACE; ignored for DEQ.
REQ-007 cmd_ready  output  1  FIFO can accept a command this cycle.
REQ-008 res_valid  output  1  result register holds an unconsumed result.
REQ-009 res_kv  output  kv_t  dequeued key/value.
REQ-010 res_err  output  1  result is a DEQ on an empty queue; res_kv is then zero.
REQ-011 res_ready  input  1  consumer accepts the result.
REQ-012 pq_enq, pq_deq  output  1 each  one-cycle strobes to the downstream PQ (quickq).
REQ-013 pq_kvi  output  kv_t  key/value presented with pq_enq.
REQ-014 pq_kvo  input  kv_t  current PQ head.
REQ-015 pq_full, pq_empty, pq_busy  input  1 each  PQ status.
REQ-016 op_count  output  16  count of PQ operations issued; wraps modulo 2^16.

Function
REQ-017 A command is accepted into the FIFO on any cycle where cmd_valid && cmd_ready; cmd_ready = !fifo_full.
REQ-018 On a simultaneous FIFO push and pop while the FIFO is full, the push is refused; while it is empty, the pushed entry is not popped in the same cycle.
REQ-019 FSM states: IDLE, ISSUE, WAIT.
REQ-020 IDLE -> ISSUE when the FIFO is non-empty, pq_busy==0, and the head command is eligible.
REQ-021 Eligibility: ENQ requires !pq_full; DEQ and REPLACE require !res_valid; NOP is always eligible.
REQ-022 An ineligible head stalls in IDLE without reordering; later commands are not issued around it.
REQ-023 ISSUE lasts exactly one cycle: the head is popped and one strobe set is driven.
REQ-024 Strobe sets: ENQ drives pq_enq=1; DEQ with !pq_empty drives pq_deq=1; REPLACE with !pq_empty drives pq_enq=pq_deq=1; REPLACE with pq_empty drives pq_enq only and produces no result.
REQ-025 DEQ with pq_empty drives no strobe and loads a result with res_err=1 and res_kv=0.
REQ-026 DEQ and REPLACE on a non-empty PQ capture pq_kvo in the ISSUE cycle; res_valid rises on the next cycle with res_err=0.
REQ-027 pq_kvi equals the head cmd_kv during ISSUE and is zero otherwise.
REQ-028 op_count increments by 1 on each ISSUE cycle that drives at least one strobe.
REQ-029 ISSUE -> WAIT always; WAIT -> IDLE on the first cycle with pq_busy==0, with a minimum of one WAIT cycle, so at most one command is issued every 2 cycles.
REQ-030 res_valid clears on res_valid && res_ready; clear and reload in the same cycle is not possible because of REQ-021.

Reset
REQ-031 On rst: state=IDLE, FIFO empty, cmd_ready=1, res_valid=0, res_kv=0, res_err=0, pq_enq=pq_deq=0, pq_kvi=0, op_count=0.
REQ-032 rst asserted in ISSUE or WAIT discards all queued commands and any pending result; the downstream PQ is reset separately by the same rst.

Structure
REQ-033 kv_t, KEY_WIDTH, VAL_WIDTH, PQ_CAPACITY, and a new pq_op_t enum for cmd_op belong in pq_pkg.
REQ-034 The command FIFO is a sub-module named cmd_fifo, parameterised on width and depth, with registered outputs.
REQ-035 FSM, result register and op_count live in pq_front.

Verification
REQ-036 After reset, ENQ keys 5, 2, 9, then DEQ x3 -> results 2, 5, 9 with res_err=0; op_count=6.
REQ-037 DEQ on an empty PQ -> no pq_deq pulse; res_valid with res_err=1 and res_kv=0; op_count unchanged.
REQ-038 pq_full forced high with ENQ at the head and a DEQ queued behind it -> no strobes and cmd_ready falls after CMD_DEPTH pushes; release pq_full -> ENQ issues first, then the DEQ.
REQ-039 res_ready held low with two DEQs queued -> the second DEQ stalls; raising res_ready -> the second issues 2 or more cycles later.
REQ-040 PQ holds key 3; REPLACE key 7 -> pq_enq and pq_deq both high for one cycle, result key 3, op_count+1.
REQ-041 rst asserted during WAIT with 3 commands queued -> the next cycle shows an empty FIFO, res_valid=0, op_count=0.
